// File: rtl/sine_pkg.sv
// Shared constants and FSM encoding for the sine angle generator.
package sine_pkg;

  localparam int unsigned ANGLE_MAX   = 360;
  localparam int unsigned ANGLE_W_DEF = 9;
  localparam int unsigned DIV_W_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ce_prescaler.sv
// Sample-rate divider: counts 0..DIV and flags the terminal count while not cleared.
module ce_prescaler
  import sine_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic [DIV_W-1:0] DIV,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt <= '0;
    end else if (cnt == DIV) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = !clear && (cnt == DIV);

endmodule

// File: rtl/sine_angle_gen.sv
// Angle sweep generator: steps W through 0..359 degrees at a divided rate,
// strobing CE for each new angle and WRAP on each 360-degree crossing.
module sine_angle_gen
  import sine_pkg::*;
#(
  parameter int unsigned ANGLE_W = ANGLE_W_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic               ONESHOT,
  input  logic [ANGLE_W-1:0] STEP,
  input  logic [DIV_W-1:0]   DIV,
  output logic [ANGLE_W-1:0] W,
  output logic               CE,
  output logic               BUSY,
  output logic               WRAP,
  output logic               ERR
);

  localparam logic [ANGLE_W:0] MAX_W = (ANGLE_W+1)'(ANGLE_MAX);

  state_t             state, state_nxt;
  logic [ANGLE_W-1:0] step_q;
  logic [DIV_W-1:0]   div_q;
  logic               oneshot_q;
  logic [ANGLE_W-1:0] w_nxt;
  logic               ce_nxt, wrap_nxt, err_nxt, latch;
  logic [ANGLE_W:0]   sum;
  logic               step_ok;
  logic               tick;

  // Held cleared outside RUN so the first RUN cycle always starts at count 0.
  ce_prescaler #(.DIV_W(DIV_W)) u_presc (
    .CLK   (CLK),
    .RST   (RST),
    .clear (state != RUN),
    .DIV   (div_q),
    .tick  (tick)
  );

  assign step_ok = (STEP != '0) && ({1'b0, STEP} < MAX_W);
  assign sum     = {1'b0, W} + {1'b0, step_q};
  assign BUSY    = (state == RUN);

  always_comb begin
    state_nxt = state;
    w_nxt     = W;
    ce_nxt    = 1'b0;
    wrap_nxt  = 1'b0;
    err_nxt   = ERR;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (START && !STOP) begin
          if (step_ok) begin
            latch     = 1'b1;
            err_nxt   = 1'b0;
            state_nxt = RUN;
            w_nxt     = '0;
            ce_nxt    = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (STOP) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (sum >= MAX_W) begin
            wrap_nxt = 1'b1;
            // A oneshot ends on the wrap without publishing the wrapped angle.
            if (oneshot_q) begin
              state_nxt = IDLE;
            end else begin
              w_nxt  = ANGLE_W'(sum - MAX_W);
              ce_nxt = 1'b1;
            end
          end else begin
            w_nxt  = sum[ANGLE_W-1:0];
            ce_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      W         <= '0;
      CE        <= 1'b0;
      WRAP      <= 1'b0;
      ERR       <= 1'b0;
      step_q    <= '0;
      div_q     <= '0;
      oneshot_q <= 1'b0;
    end else begin
      state <= state_nxt;
      W     <= w_nxt;
      CE    <= ce_nxt;
      WRAP  <= wrap_nxt;
      ERR   <= err_nxt;
      if (latch) begin
        step_q    <= STEP;
        div_q     <= DIV;
        oneshot_q <= ONESHOT;
      end
    end
  end

endmodule

// File: tb/tb_sine_angle_gen.sv
// Bench for sine_angle_gen: arithmetic reference model checked every cycle,
// plus directed sweeps with hand-computed angle expectations.
module tb_sine_angle_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, oneshot;
  logic [8:0]  step;
  logic [15:0] div;
  logic [8:0]  w;
  logic        ce, busy, wrap, err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sine_angle_gen #(.ANGLE_W(9), .DIV_W(16)) dut (
    .CLK     (clk),
    .RST     (rst),
    .START   (start),
    .STOP    (stop),
    .ONESHOT (oneshot),
    .STEP    (step),
    .DIV     (div),
    .W       (w),
    .CE      (ce),
    .BUSY    (busy),
    .WRAP    (wrap),
    .ERR     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference model: time since sweep start decides when the angle advances.
  int m_w, m_step, m_div, m_t;
  bit m_ce, m_wrap, m_busy, m_err, m_os;

  always @(posedge clk) begin
    int s;
    m_ce   = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_w = 0; m_busy = 0; m_err = 0; m_step = 0; m_div = 0; m_os = 0; m_t = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        if (step >= 1 && step <= 359) begin
          m_step = step; m_div = div; m_os = oneshot;
          m_err = 0; m_busy = 1; m_w = 0; m_ce = 1; m_t = 0;
        end else begin
          m_err = 1;
        end
      end
    end else begin
      if (stop) begin
        m_busy = 0;
      end else begin
        m_t = m_t + 1;
        if (m_t % (m_div + 1) == 0) begin
          s = m_w + m_step;
          if (s >= 360) begin
            m_wrap = 1;
            if (m_os) m_busy = 0;
            else begin m_w = s - 360; m_ce = 1; end
          end else begin
            m_w = s; m_ce = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_w",    w,    m_w);
      check("model_ce",   ce,   m_ce);
      check("model_busy", busy, m_busy);
      check("model_wrap", wrap, m_wrap);
      check("model_err",  err,  m_err);
    end
  end

  initial begin
    int exp_w[5] = '{0, 90, 180, 270, 0};
    rst = 1; start = 0; stop = 0; oneshot = 0; step = '0; div = '0;
    cyc(); cyc();
    chk_en = 1'b1;
    check("rst_w", w, 0); check("rst_ce", ce, 0); check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0); check("rst_err", err, 0);
    rst = 0;
    cyc();

    // Continuous sweep, STEP=90 DIV=3; inputs disturbed mid-run
    step = 90; div = 3; oneshot = 0; start = 1;
    cyc(); start = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) cyc();
      if (c == 3) begin step = 13; div = 0; start = 1; end
      if (c == 4) begin step = 90; div = 3; start = 0; end
      if ((c - 1) % 4 == 0) begin
        check("sweep_ce", ce, 1);
        check("sweep_w", w, exp_w[(c - 1) / 4]);
      end
      check("sweep_wrap", wrap, (c == 17) ? 1 : 0);
    end
    stop = 1; cyc(); stop = 0;
    check("sweep_stop_busy", busy, 0); check("sweep_stop_w", w, 0);
    cyc();

    // Non-divisible wrap, STEP=7 DIV=0
    step = 7; div = 0; start = 1;
    cyc(); start = 0;
    for (int c = 2; c <= 54; c++) begin
      cyc();
      if (c == 51) check("nd_w51", w, 350);
      if (c == 52) begin check("nd_w52", w, 357); check("nd_wrap52", wrap, 0); end
      if (c == 53) begin check("nd_w53", w, 4); check("nd_wrap53", wrap, 1); check("nd_ce53", ce, 1); end
      if (c == 54) begin check("nd_w54", w, 11); check("nd_wrap54", wrap, 0); end
    end
    stop = 1; cyc(); stop = 0; cyc();

    // Oneshot, STEP=120 DIV=0
    step = 120; div = 0; oneshot = 1; start = 1;
    cyc(); start = 0; oneshot = 0;
    check("os_w1", w, 0); check("os_ce1", ce, 1);
    cyc(); check("os_w2", w, 120);
    cyc(); check("os_w3", w, 240); check("os_ce3", ce, 1);
    cyc(); check("os_wrap4", wrap, 1); check("os_ce4", ce, 0);
    check("os_busy4", busy, 0); check("os_w4", w, 240);
    cyc(); check("os_wrap5", wrap, 0); check("os_w5", w, 240);

    // Illegal steps, then a legal start clears ERR
    step = 0; start = 1; cyc(); start = 0;
    check("ill0_err", err, 1); check("ill0_busy", busy, 0); check("ill0_ce", ce, 0);
    step = 360; start = 1; cyc(); start = 0;
    check("ill360_err", err, 1); check("ill360_busy", busy, 0);
    cyc(); check("ill_sticky", err, 1);
    step = 45; start = 1; cyc(); start = 0;
    check("ok45_err", err, 0); check("ok45_busy", busy, 1); check("ok45_w", w, 0);
    cyc(); check("ok45_w2", w, 45);
    stop = 1; cyc(); stop = 0;

    // Contention and STOP mid-run
    step = 90; start = 1; stop = 1; cyc(); start = 0; stop = 0;
    check("both_busy", busy, 0); check("both_ce", ce, 0);
    start = 1; cyc(); start = 0;
    cyc(); cyc(); check("stop_pre_w", w, 180);
    stop = 1; cyc(); stop = 0;
    check("stop_busy", busy, 0); check("stop_ce", ce, 0); check("stop_w", w, 180);
    cyc(); check("stop_hold_w", w, 180);

    // Reset clears ERR, and reset mid-sweep
    step = 0; start = 1; cyc(); start = 0;
    check("pre_rst_err", err, 1);
    rst = 1; cyc(); rst = 0;
    check("rst_err_clr", err, 0);
    step = 90; start = 1; cyc(); start = 0;
    cyc(); cyc(); cyc();
    check("mid_w", w, 270); check("mid_busy", busy, 1);
    rst = 1; cyc(); rst = 0;
    check("mid_rst_w", w, 0); check("mid_rst_ce", ce, 0);
    check("mid_rst_busy", busy, 0); check("mid_rst_err", err, 0);
    start = 1; cyc(); start = 0;
    check("restart_w", w, 0); check("restart_ce", ce, 1); check("restart_busy", busy, 1);
    stop = 1; cyc(); stop = 0; cyc(); cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
